// File: rtl/spi_pkg.sv
// Shared state/op encodings and default widths for the SPI initiator slice.
package spi_pkg;

    localparam int CMD_SIZE = 10;
    localparam int RD_SIZE  = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        CMD,
        SHIFT,
        HOLD,
        WAIT,
        RECV,
        END
    } state_t;

    typedef enum logic [1:0] {
        OP_WR_ADDR = 2'b00,
        OP_WR_DATA = 2'b01,
        OP_RD_ADDR = 2'b10,
        OP_RD_DATA = 2'b11
    } op_t;

endpackage

// File: rtl/spi_master_if.sv
// Command/response bus plus SPI pins of spi_master; SCLK exists only when
// SPI_MASTER_SCLK_EN is defined.
interface spi_master_if #(
    parameter int CMD_SIZE = spi_pkg::CMD_SIZE,
    parameter int RD_SIZE  = spi_pkg::RD_SIZE
);
    import spi_pkg::*;

    // Handshake: a command transfers on any clk edge where cmd_valid && cmd_ready;
    // cmd_ready is high only in IDLE, and cmd_data is sampled on that edge alone.
    logic [CMD_SIZE-1:0] cmd_data;
    logic                cmd_valid;
    logic                cmd_ready;
    logic                MOSI;
    logic                MISO;
    logic                SS_n;
`ifdef SPI_MASTER_SCLK_EN
    logic                SCLK;
`endif
    logic [RD_SIZE-1:0]  rd_data;
    logic                rd_valid;
    logic                cmd_err;
    logic                busy;
    state_t              dbg_state;

`ifdef SPI_MASTER_SCLK_EN
    modport master (
        input  cmd_data, cmd_valid, MISO,
        output cmd_ready, MOSI, SS_n, SCLK, rd_data, rd_valid, cmd_err, busy, dbg_state
    );
    modport slave (
        output cmd_data, cmd_valid, MISO,
        input  cmd_ready, MOSI, SS_n, SCLK, rd_data, rd_valid, cmd_err, busy, dbg_state
    );
`else
    modport master (
        input  cmd_data, cmd_valid, MISO,
        output cmd_ready, MOSI, SS_n, rd_data, rd_valid, cmd_err, busy, dbg_state
    );
    modport slave (
        output cmd_data, cmd_valid, MISO,
        input  cmd_ready, MOSI, SS_n, rd_data, rd_valid, cmd_err, busy, dbg_state
    );
`endif

endinterface

// File: rtl/spi_master_shifter.sv
// Shift register shared by the transmit and receive phases: the MSB leaves on
// serial_out while serial_in enters at the LSB; done marks the final bit.
module spi_master_shifter #(
    parameter int W  = spi_pkg::CMD_SIZE,
    parameter int RW = spi_pkg::RD_SIZE,
    parameter int CW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [W-1:0]  load_data,
    input  logic [CW-1:0] load_count,
    input  logic          shift_en,
    input  logic          serial_in,
    output logic          serial_out,
    output logic [RW-1:0] rx_word,
    output logic          done
);

    logic [W-1:0]  q;
    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            q     <= '0;
            count <= '0;
        end else if (load) begin
            q     <= load_data;
            count <= load_count;
        end else if (shift_en) begin
            q <= {q[W-2:0], serial_in};
            if (count != '0) count <= count - CW'(1);
        end
    end

    assign serial_out = q[W-1];
    // Word as it will look once the bit arriving now is shifted in.
    assign rx_word    = {q[RW-2:0], serial_in};
    assign done       = (count == CW'(1));

endmodule

// File: rtl/spi_master.sv
// SPI initiator: serialises 10-bit commands MSB-first under SS_n and returns a
// read byte for read-data. Define SPI_MASTER_SCLK_EN for a 2-clk-per-bit SCLK.
module spi_master #(
    parameter int CMD_SIZE   = spi_pkg::CMD_SIZE,
    parameter int RD_SIZE    = spi_pkg::RD_SIZE,
    parameter int RD_LATENCY = 2,
    parameter int GAP_CYCLES = 1
) (
    input  logic         clk,
    input  logic         rst,
    spi_master_if.master bus
);
    import spi_pkg::*;

    localparam int CW = $clog2(CMD_SIZE + 1);
    localparam int LW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_t              state, state_next;
    op_t                 op_q, cmd_op;
    logic                pending;
    logic [LW-1:0]       wait_cnt;
    logic [GW-1:0]       gap_cnt;
    logic                tick;
    logic                accept, illegal, recv_last;
    logic                sh_load, sh_shift, sh_in, sh_out, sh_done;
    logic [CMD_SIZE-1:0] sh_load_data;
    logic [CW-1:0]       sh_load_count;
    logic [RD_SIZE-1:0]  sh_rx, rd_data_q;
    logic                rd_valid_q, cmd_err_q;
    logic                ss_n_c, mosi_c, ready_c, busy_c;

    assign cmd_op    = op_t'(bus.cmd_data[CMD_SIZE-1 -: 2]);
    assign accept    = (state == IDLE) && bus.cmd_valid;
    assign illegal   = (cmd_op == OP_RD_DATA) && !pending;
    assign recv_last = (state == RECV) && tick && sh_done;

`ifdef SPI_MASTER_SCLK_EN
    // half=0 is the SCLK-low half of a bit; the FSM and shifter advance only
    // at the end of the high half.
    logic half, bit_phase;
    assign bit_phase = (state == CMD) || (state == SHIFT) || (state == WAIT) || (state == RECV);
    always_ff @(posedge clk) begin
        if (rst || !bit_phase) half <= 1'b0;
        else                   half <= ~half;
    end
    assign tick     = half;
    assign bus.SCLK = bit_phase && half;
`else
    assign tick = 1'b1;
`endif

    // HOLD reloads the shifter with the receive count; harmless for writes.
    assign sh_load       = accept || (state == HOLD);
    assign sh_load_data  = accept ? bus.cmd_data : '0;
    assign sh_load_count = accept ? CW'(CMD_SIZE) : CW'(RD_SIZE);
    assign sh_shift      = tick && ((state == SHIFT) || (state == RECV));
    assign sh_in         = (state == RECV) ? bus.MISO : 1'b0;

    spi_master_shifter #(.W(CMD_SIZE), .RW(RD_SIZE), .CW(CW)) u_shifter (
        .clk        (clk),
        .rst        (rst),
        .load       (sh_load),
        .load_data  (sh_load_data),
        .load_count (sh_load_count),
        .shift_en   (sh_shift),
        .serial_in  (sh_in),
        .serial_out (sh_out),
        .rx_word    (sh_rx),
        .done       (sh_done)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = illegal ? END : START;
            START:   state_next = CMD;
            CMD:     if (tick) state_next = SHIFT;
            SHIFT:   if (tick && sh_done) state_next = HOLD;
            HOLD:    state_next = (op_q == OP_RD_DATA) ? WAIT : END;
            WAIT:    if (tick && (wait_cnt == LW'(RD_LATENCY - 1))) state_next = RECV;
            RECV:    if (tick && sh_done) state_next = END;
            END:     if (gap_cnt == GW'(GAP_CYCLES - 1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ss_n_c  = 1'b1;
        mosi_c  = 1'b0;
        ready_c = 1'b0;
        busy_c  = 1'b1;
        case (state)
            IDLE: begin
                ready_c = !rst;
                busy_c  = 1'b0;
            end
            START, HOLD, WAIT, RECV: ss_n_c = 1'b0;
            CMD, SHIFT: begin
                ss_n_c = 1'b0;
                mosi_c = sh_out;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= OP_WR_ADDR;
            pending    <= 1'b0;
            wait_cnt   <= '0;
            gap_cnt    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            rd_valid_q <= recv_last;
            cmd_err_q  <= accept && illegal;
            if (accept) op_q <= cmd_op;
            if ((state == HOLD) && (op_q == OP_RD_ADDR)) pending <= 1'b1;
            if (recv_last) begin
                pending   <= 1'b0;
                rd_data_q <= sh_rx;
            end
            if (state != WAIT) wait_cnt <= '0;
            else if (tick)     wait_cnt <= wait_cnt + LW'(1);
            gap_cnt <= (state == END) ? gap_cnt + GW'(1) : '0;
        end
    end

    assign bus.SS_n      = ss_n_c;
    assign bus.MOSI      = mosi_c;
    assign bus.cmd_ready = ready_c;
    assign bus.busy      = busy_c;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.cmd_err   = cmd_err_q;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: scoreboard queues hold the expected MOSI frame
// and read bytes; a slave model in send() returns MISO during the receive window.
module tb_spi_master;
    import spi_pkg::*;

    localparam int RD_LAT = 2;
    localparam int GAP    = 1;
    localparam int RS     = 1 + 1 + CMD_SIZE + 1 + RD_LAT;

    logic clk = 1'b0;
    logic rst;

    spi_master_if bus ();

    spi_master #(.RD_LATENCY(RD_LAT), .GAP_CYCLES(GAP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [12:0] exp_q[$];
    logic [7:0]  rd_q[$];

    int          low_cnt, rdv_cnt, err_cnt, ready_at;
    logic [12:0] mosi_vec;
    logic [7:0]  rd_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_frame(input logic [9:0] cmd);
        exp_q.push_back({1'b0, cmd[9], cmd, 1'b0});
    endtask

    // Call at a negedge with the DUT idle; returns once cmd_ready is back or the budget runs out.
    task automatic send(input logic [9:0] cmd, input logic [7:0] miso_byte);
        bus.cmd_data  = cmd;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = CMD_SIZE'($urandom);
        low_cnt = 0; rdv_cnt = 0; err_cnt = 0; ready_at = -1;
        mosi_vec = '0; rd_seen = '0;
        for (int c = 0; c < 60; c++) begin
            if (!bus.SS_n) begin
                if (low_cnt < 13) mosi_vec = {mosi_vec[11:0], bus.MOSI};
                if (low_cnt >= RS && low_cnt < RS + RD_SIZE)
                    bus.MISO = miso_byte[RD_SIZE - 1 - (low_cnt - RS)];
                else
                    bus.MISO = 1'($urandom_range(0, 1));
                low_cnt++;
            end else begin
                bus.MISO = 1'($urandom_range(0, 1));
            end
            if (bus.rd_valid) begin
                rdv_cnt++;
                rd_seen = bus.rd_data;
            end
            if (bus.cmd_err) err_cnt++;
            if (bus.cmd_ready) begin
                ready_at = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        logic [9:0]  cmd_a, cmd_b;
        logic [12:0] vec, vec_a, vec_b;
        logic [7:0]  last_rd;
        int          frames, gap, gap_seen, nbits;
        bit          in_low;

        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = '0;
        bus.MISO      = 1'b0;
        last_rd       = '0;
        repeat (3) @(negedge clk);
        check("rst_ss_n", bus.SS_n, 1);
        check("rst_mosi", bus.MOSI, 0);
        check("rst_ready", bus.cmd_ready, 0);
        check("rst_rd_data", bus.rd_data, 0);
        check("rst_rd_valid", bus.rd_valid, 0);
        check("rst_cmd_err", bus.cmd_err, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_state", bus.dbg_state, IDLE);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", bus.cmd_ready, 1);

`ifdef SPI_MASTER_SCLK_EN
        begin
            int rises, unstable, sclk_bad, low;
            logic prev_sclk, prev_mosi;
            logic [10:0] sv;
            cmd_a = 10'h155;
            exp_q.push_back({2'b00, cmd_a[9], cmd_a});
            bus.cmd_data = cmd_a; bus.cmd_valid = 1'b1;
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            rises = 0; unstable = 0; sclk_bad = 0; low = 0;
            prev_sclk = 1'b0; prev_mosi = 1'b0; sv = '0;
            for (int c = 0; c < 80; c++) begin
                if (!bus.SS_n) begin
                    low++;
                    if (bus.SCLK && !prev_sclk) rises++;
                    if (bus.SCLK) begin
                        sv = {sv[9:0], bus.MOSI};
                        if (bus.MOSI !== prev_mosi) unstable++;
                    end
                end else begin
                    if (bus.SCLK !== 1'b0) sclk_bad++;
                    if (low > 0 && bus.cmd_ready) break;
                end
                prev_sclk = bus.SCLK;
                prev_mosi = bus.MOSI;
                @(negedge clk);
            end
            check("sclk_low_len", low, 24);
            check("sclk_periods", rises, 11);
            check("sclk_mosi_bits", {2'b00, sv}, exp_q.pop_front());
            check("sclk_mosi_stable", unstable, 0);
            check("sclk_idle_low", sclk_bad, 0);
            send(10'h3FF, 8'h00);
            check("sclk_illegal_low", low_cnt, 0);
            check("sclk_illegal_err", err_cnt, 1);
            check("sclk_idle_level", bus.SCLK, 0);
        end
`else
        // Write-addr frame.
        expect_frame(10'h0A5);
        send(10'h0A5, 8'h00);
        check("wa_low_len", low_cnt, 13);
        check("wa_mosi", mosi_vec, exp_q.pop_front());
        check("wa_rd_valid", rdv_cnt, 0);
        check("wa_ready_at", ready_at, 14);

        // Read-addr then read-data with the slave returning C6.
        expect_frame(10'h233);
        send(10'h233, 8'h00);
        check("ra_low_len", low_cnt, 13);
        check("ra_mosi", mosi_vec, exp_q.pop_front());
        expect_frame(10'h300);
        rd_q.push_back(8'hC6);
        send(10'h300, 8'hC6);
        check("rd_low_len", low_cnt, 23);
        check("rd_mosi", mosi_vec, exp_q.pop_front());
        check("rd_valid_pulses", rdv_cnt, 1);
        last_rd = rd_q.pop_front();
        check("rd_data", rd_seen, last_rd);
        check("rd_ready_at", ready_at, 24);
        check("rd_err", err_cnt, 0);

        // Pending was consumed: another read-data is dropped with cmd_err.
        send(10'h3FF, 8'hA5);
        check("ill_low_len", low_cnt, 0);
        check("ill_err", err_cnt, 1);
        check("ill_rd_valid", rdv_cnt, 0);
        check("ill_ready_at", ready_at, 1);
        check("rd_data_hold", bus.rd_data, last_rd);

        // Reset in the middle of SHIFT while a read address is pending.
        expect_frame(10'h25A);
        send(10'h25A, 8'h00);
        check("ra2_mosi", mosi_vec, exp_q.pop_front());
        cmd_a = 10'h1C3;
        bus.cmd_data = cmd_a; bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("mid_shift_mosi", bus.MOSI, cmd_a[5]);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_ss_n", bus.SS_n, 1);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_mosi", bus.MOSI, 0);
        check("mid_rst_rd_valid", bus.rd_valid, 0);
        check("mid_rst_state", bus.dbg_state, IDLE);
        rst = 1'b0;
        @(negedge clk);
        send(10'h300, 8'h5A);
        check("post_rst_err", err_cnt, 1);
        check("post_rst_low", low_cnt, 0);

        // cmd_valid held high across two write commands.
        cmd_a = 10'h16C;
        cmd_b = 10'h0F1;
        expect_frame(cmd_a);
        expect_frame(cmd_b);
        bus.cmd_data = cmd_a; bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_data = cmd_b;
        frames = 1; in_low = 1'b1; nbits = 0; gap = 0; gap_seen = -1;
        vec = '0; vec_a = '0; vec_b = '0;
        for (int c = 0; c < 80; c++) begin
            if (!bus.SS_n) begin
                if (!in_low) begin
                    frames++;
                    gap_seen = gap;
                    in_low = 1'b1;
                    nbits = 0;
                    vec = '0;
                    if (frames == 2) begin
                        bus.cmd_valid = 1'b0;
                        bus.cmd_data  = '1;
                    end
                end
                if (nbits < 13) begin
                    vec = {vec[11:0], bus.MOSI};
                    nbits++;
                end
            end else begin
                if (in_low) begin
                    in_low = 1'b0;
                    gap = 0;
                    if (frames == 1) vec_a = vec;
                    else             vec_b = vec;
                end
                gap++;
                if (frames >= 2 && gap == 4) break;
            end
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        check("b2b_frames", frames, 2);
        check("b2b_gap", gap_seen, GAP + 1);
        check("b2b_mosi_a", vec_a, exp_q.pop_front());
        check("b2b_mosi_b", vec_b, exp_q.pop_front());
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
